instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the 16-bit CPU. Owns the program counter and drives it into the InstructionMemory address port. It captures the returned 16-bit instruction, together with the PC it was fetched from, into an instruction register. That register is handed to decode over a valid/ready handshake, and the stage accepts a redirect for branches and jumps.

## Interface
Parameters:
- PC_WIDTH, 16, program counter and redirect target width
- INSTR_WIDTH, 16, instruction width
- RESET_PC, 16'h0000, PC value loaded on reset
- PC_STEP, 2, byte increment per instruction (memory is byte-addressed, 16-bit words)

Ports:
- Clock, input, 1, sole clock; all state updates on its rising edge
- Reset, input, 1, synchronous, active-high
- PC, output, PC_WIDTH, address to InstructionMemory; driven directly from the PC register
- Instruction, input, INSTR_WIDTH, InstructionMemory read data; combinational function of PC
- RedirectValid, input, 1, branch/jump taken this cycle
- RedirectTarget, input, PC_WIDTH, new PC; bit 0 is ignored and forced to 0
- IrValid, output, 1, IrData/IrPC hold a valid instruction
- IrReady, input, 1, decode accepts the instruction this cycle
- IrData, output, INSTR_WIDTH, registered instruction
- IrPC, output, PC_WIDTH, address IrData was fetched from
- Halted, output, 1, fetch is stopped on a HALT; constant 0 without HALTED_FETCH_EN

## Operation
- Definition: fire = IrValid & IrReady. Definition: load = !IrValid | fire.
- States: RUN and HALT. HALT exists only with HALTED_FETCH_EN.
- Priority order is Reset > RedirectValid > normal fetch.
- Reset:
  - PC <= RESET_PC; IrValid <= 0; IrData <= 0; IrPC <= 0; state <= RUN; Halted <= 0.
- Redirect, in any state:
  - PC <= {RedirectTarget[PC_WIDTH-1:1], 1'b0}; IrValid <= 0 (flush); state <= RUN.
  - The instruction at the current PC is discarded, even if fire or load is true.
- RUN with load:
  - IrData <= Instruction; IrPC <= PC; IrValid <= 1; PC <= PC + PC_STEP.
- RUN without load: PC and IR hold (stall). IrData and IrPC must not change while IrValid=1 and IrReady=0.
- HALT:
  - PC frozen; no new captures.
  - IR keeps the HALT instruction until fire, then IrValid <= 0.
- Arithmetic: PC + PC_STEP is modulo 2^PC_WIDTH, so 16'hFFFE wraps to 16'h0000 with no flag.

## Timing
- Fetch-to-IR latency is 1 cycle: Instruction sampled at PC in cycle N appears on IrData in cycle N+1.
- Throughput is 1 instruction per cycle while IrReady is held high.
- Redirect penalty: redirect asserted in cycle N gives IrValid=0 in N+1. The target instruction is valid in N+2.
- Reset values are as listed in Operation. The first valid instruction appears in the cycle after Reset deasserts, with IrPC=RESET_PC.
- Reset asserted mid-stall or mid-halt takes effect at the next edge, overriding redirect and handshake.
- IrValid never drops without fire, redirect or Reset.

## Configuration
- Macro: HALTED_FETCH_EN.
- Defined:
  - Capturing an instruction with Instruction[15:12] == 4'hF also sets state <= HALT and Halted <= 1.
  - PC is not advanced past the HALT.
  - Halted clears only on Redirect or Reset.
- Undefined:
  - Opcode 4'hF is fetched like any other instruction.
  - No HALT state; Halted is tied to 0.

## Structure
- A shared package cpu_pkg holds:
  - PC_WIDTH and INSTR_WIDTH defaults
  - OPCODE_HALT = 4'hF
  - the opcode field position [15:12]
  - the fetch state encoding (RUN=0, HALT=1)
- One sub-module, fetch_pc_reg, is natural: the PC register with reset, redirect-load, increment and hold.
- The IR register, handshake and halt state machine live in instruction_fetch.
- The top-level CPU instantiates instruction_fetch next to InstructionMemory: PC→PC, Instruction→Instruction.

## Test plan
- Reset, IrReady=1, memory returning the addresses' contents -> IrPC sequence 0,2,4,6 on consecutive cycles; IrValid=1 from the first cycle after Reset deasserts.
- IrReady=0 for 3 cycles while IrValid=1 with IrPC=4 -> IrData/IrPC/PC stable; resumes IrPC=6 one cycle after IrReady=1.
- RedirectValid with target 16'h0031 while IrReady=0 -> next cycle IrValid=0 and PC=16'h0030; the following cycle IrPC=16'h0030.
- Redirect to 16'hFFFE with IrReady=1 -> IrPC=16'hFFFE, then IrPC=16'h0000 (wrap).
- HALTED_FETCH_EN defined, instruction 16'hF000 at address 8 -> IrPC=8, Halted=1, PC stays 8 (not advanced past the HALT). After fire, IrValid=0 persists until a redirect to 0, after which Halted=0 and fetch resumes at 0.
- Reset asserted during HALT, or during a stall with IrValid=1 -> next cycle PC=RESET_PC, IrValid=0, IrData=0, Halted=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit CPU: default datapath widths, the opcode
// field position, the HALT opcode and the fetch-stage state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_WIDTH_DEFAULT    = 16;
    localparam int INSTR_WIDTH_DEFAULT = 16;

    // Opcode lives in the top nibble of every instruction.
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;

    localparam logic [3:0] OPCODE_HALT = 4'hF;

    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    function automatic logic is_halt_opcode(input logic [3:0] opcode);
        return opcode == OPCODE_HALT;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
// Program counter register for the fetch stage. Priority: reset, then
// redirect (target with bit 0 cleared), then advance by PC_STEP, else hold.
// The increment wraps modulo 2^PC_WIDTH.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, loads RESET_PC
//   redirect in   load the aligned redirect target
//   target   in   redirect target, bit 0 is dropped
//   advance  in   step the PC by PC_STEP
//   pc       out  current program counter
// -----------------------------------------------------------------------------
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = PC_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  PC_STEP  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] target,
    input  logic                advance,
    output logic [PC_WIDTH-1:0] pc
);

    // Instructions are halfword aligned; masking keeps every target bit read.
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target & ALIGN_MASK;
        end else if (advance) begin
            pc <= pc + STEP;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage of the 16-bit CPU. Drives PC to InstructionMemory, captures the
// returned instruction plus its PC into an instruction register (IR), and
// offers the IR to decode over a valid/ready handshake. Redirects flush the
// IR and reload the PC.
//
// Handshake: IrValid/IrData/IrPC form a valid/ready source. A transfer (fire)
// happens on a rising edge where IrValid and IrReady are both high. Once
// IrValid is high, IrData/IrPC stay stable and IrValid stays high until fire,
// a redirect or reset; IrReady may be driven freely by decode.
//
// Optional feature (macro HALTED_FETCH_EN): capturing an opcode 4'hF moves the
// stage to HALT, which freezes the PC and stops captures until a redirect or
// reset. Without the macro, 4'hF is an ordinary instruction and Halted is 0.
//
// Ports:
//   Clock          in   clock, rising edge
//   Reset          in   synchronous active-high reset
//   PC             out  instruction memory address (PC register)
//   Instruction    in   instruction memory read data for PC
//   RedirectValid  in   branch/jump taken this cycle
//   RedirectTarget in   new PC, bit 0 forced to 0
//   IrValid        out  IR holds a valid instruction
//   IrReady        in   decode accepts the IR this cycle
//   IrData         out  registered instruction
//   IrPC           out  address IrData was fetched from
//   Halted         out  fetch stopped on HALT
//   FetchState     out  current fetch FSM state (observation only)
// -----------------------------------------------------------------------------
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter int                  INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  PC_STEP     = 2
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [PC_WIDTH-1:0]    PC,
    input  logic [INSTR_WIDTH-1:0] Instruction,
    input  logic                   RedirectValid,
    input  logic [PC_WIDTH-1:0]    RedirectTarget,
    output logic                   IrValid,
    input  logic                   IrReady,
    output logic [INSTR_WIDTH-1:0] IrData,
    output logic [PC_WIDTH-1:0]    IrPC,
    output logic                   Halted,
    output fetch_state_e           FetchState
);

    logic         fire;
    logic         load;
    logic         capture;
    logic         advance;
    logic         valid_next;
    fetch_state_e state;
    fetch_state_e state_next;

    assign fire = IrValid & IrReady;
    assign load = !IrValid | fire;

    fetch_pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk      (Clock),
        .rst      (Reset),
        .redirect (RedirectValid),
        .target   (RedirectTarget),
        .advance  (advance),
        .pc       (PC)
    );

    // State register. In the default build state_next is always RUN, so
    // HALT is unreachable and the flop reduces to a constant.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= FETCH_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        valid_next = IrValid;
        capture    = 1'b0;
        advance    = 1'b0;
        if (RedirectValid) begin
            // Flush: whatever sits at the current PC is dropped, even if
            // decode is taking the IR this very cycle.
            state_next = FETCH_RUN;
            valid_next = 1'b0;
        end else if (state == FETCH_RUN) begin
            if (load) begin
                capture    = 1'b1;
                valid_next = 1'b1;
                advance    = 1'b1;
`ifdef HALTED_FETCH_EN
                // Keep PC pointing at the HALT so a later redirect or reset
                // is the only way forward.
                if (is_halt_opcode(Instruction[OPCODE_MSB:OPCODE_LSB])) begin
                    advance    = 1'b0;
                    state_next = FETCH_HALT;
                end
`endif
            end
        end else begin
            // HALT: hand the HALT instruction over, then sit empty.
            if (fire) begin
                valid_next = 1'b0;
            end
        end
    end

    // Instruction register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            IrValid <= 1'b0;
            IrData  <= '0;
            IrPC    <= '0;
        end else begin
            IrValid <= valid_next;
            if (capture) begin
                IrData <= Instruction;
                IrPC   <= PC;
            end
        end
    end

`ifdef HALTED_FETCH_EN
    assign Halted = (state == FETCH_HALT);
`else
    assign Halted = 1'b0;
`endif

    assign FetchState = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed, table-driven bench for instruction_fetch. A behavioural memory
// returns {4'h1, addr[11:0]} for every address, optionally with a HALT
// (16'hF000) planted at address 8. Table rows cover reset, streaming, stall,
// redirects and wrap; hand-written sequences cover HALT and reset during
// stall/halt. Build with +define+HALTED_FETCH_EN to exercise the HALT path.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;
    import cpu_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [15:0]  pc;
    logic [15:0]  instruction;
    logic         redirect_valid;
    logic [15:0]  redirect_target;
    logic         ir_valid;
    logic         ir_ready;
    logic [15:0]  ir_data;
    logic [15:0]  ir_pc;
    logic         halted;
    fetch_state_e fetch_state;
    logic         plant_halt;

    int n_compared   = 0;
    int n_mismatched = 0;

    instruction_fetch dut (
        .Clock          (clk),
        .Reset          (reset),
        .PC             (pc),
        .Instruction    (instruction),
        .RedirectValid  (redirect_valid),
        .RedirectTarget (redirect_target),
        .IrValid        (ir_valid),
        .IrReady        (ir_ready),
        .IrData         (ir_data),
        .IrPC           (ir_pc),
        .Halted         (halted),
        .FetchState     (fetch_state)
    );

    // ---------------- memory model ----------------
    function automatic logic [15:0] mem_model(input logic [15:0] addr, input logic plant);
        if (plant && addr == 16'h0008) return 16'hF000;
        return {4'h1, addr[11:0]};
    endfunction

    assign instruction = mem_model(pc, plant_halt);

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive inputs away from the edge, clock once, settle for sampling.
    task automatic step(input logic rst, input logic rv, input logic [15:0] rt, input logic rdy);
        @(negedge clk);
        reset           = rst;
        redirect_valid  = rv;
        redirect_target = rt;
        ir_ready        = rdy;
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    localparam int IR_SKIP  = 0;  // IR contents not checked (flushed/hold undefined)
    localparam int IR_MEM   = 1;  // IrPC == exp_irpc, IrData == memory at exp_irpc
    localparam int IR_RESET = 2;  // IrPC == 0, IrData == 0

    typedef struct {
        logic        rst;
        logic        rv;
        logic [15:0] rt;
        logic        rdy;
        logic [15:0] exp_pc;
        logic        exp_valid;
        int          ir_mode;
        logic [15:0] exp_irpc;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        ir_ready        = 1'b0;
        plant_halt      = 1'b0;

        //           rst   rv    rt        rdy   pc        v     ir_mode   irpc
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, IR_RESET, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, IR_MEM,   16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, IR_MEM,   16'h0002};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, IR_MEM,   16'h0004};
        // stall three cycles holding IrPC=4
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, IR_MEM,   16'h0004};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, IR_MEM,   16'h0004};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, IR_MEM,   16'h0004};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, IR_MEM,   16'h0006};
        // redirect to odd target while stalled
        vecs[8]  = '{1'b0, 1'b1, 16'h0031, 1'b0, 16'h0030, 1'b0, IR_SKIP,  16'h0000};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0032, 1'b1, IR_MEM,   16'h0030};
        // redirect while firing, then wrap past 16'hFFFE
        vecs[10] = '{1'b0, 1'b1, 16'hFFFE, 1'b1, 16'hFFFE, 1'b0, IR_SKIP,  16'h0000};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, IR_MEM,   16'hFFFE};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, IR_MEM,   16'h0000};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, IR_MEM,   16'h0000};
        // reset mid-stall beats a simultaneous redirect
        vecs[14] = '{1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, IR_RESET, 16'h0000};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, IR_MEM,   16'h0000};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].rv, vecs[i].rt, vecs[i].rdy);
            check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            check($sformatf("v%0d_valid", i), 32'(ir_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_halted", i), 32'(halted), 32'(1'b0));
            check($sformatf("v%0d_state", i), 32'(fetch_state), 32'(FETCH_RUN));
            if (vecs[i].ir_mode == IR_MEM) begin
                check($sformatf("v%0d_irpc", i), 32'(ir_pc), 32'(vecs[i].exp_irpc));
                check($sformatf("v%0d_irdata", i), 32'(ir_data),
                      32'(mem_model(vecs[i].exp_irpc, 1'b0)));
            end else if (vecs[i].ir_mode == IR_RESET) begin
                check($sformatf("v%0d_irpc_rst", i), 32'(ir_pc), 32'(16'h0000));
                check($sformatf("v%0d_irdata_rst", i), 32'(ir_data), 32'(16'h0000));
            end
        end

        // ---------------- HALT sequence ----------------
        plant_halt = 1'b1;
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("h_pre_irpc", 32'(ir_pc), 32'(16'h0006));
        step(1'b0, 1'b0, 16'h0000, 1'b1);   // captures word at address 8
        check("h_cap_irpc", 32'(ir_pc), 32'(16'h0008));
        check("h_cap_irdata", 32'(ir_data), 32'(16'hF000));
        check("h_cap_valid", 32'(ir_valid), 32'(1'b1));
`ifdef HALTED_FETCH_EN
        check("h_cap_halted", 32'(halted), 32'(1'b1));
        check("h_cap_pc", 32'(pc), 32'(16'h0008));
        check("h_cap_state", 32'(fetch_state), 32'(FETCH_HALT));
        step(1'b0, 1'b0, 16'h0000, 1'b1);   // decode takes the HALT
        check("h_fire_valid", 32'(ir_valid), 32'(1'b0));
        check("h_fire_halted", 32'(halted), 32'(1'b1));
        check("h_fire_pc", 32'(pc), 32'(16'h0008));
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b1);
            check($sformatf("h_idle%0d_valid", k), 32'(ir_valid), 32'(1'b0));
            check($sformatf("h_idle%0d_pc", k), 32'(pc), 32'(16'h0008));
        end
        step(1'b0, 1'b1, 16'h0000, 1'b1);   // redirect leaves HALT
        check("h_redir_halted", 32'(halted), 32'(1'b0));
        check("h_redir_valid", 32'(ir_valid), 32'(1'b0));
        check("h_redir_pc", 32'(pc), 32'(16'h0000));
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("h_resume_irpc", 32'(ir_pc), 32'(16'h0000));
        check("h_resume_valid", 32'(ir_valid), 32'(1'b1));
        check("h_resume_pc", 32'(pc), 32'(16'h0002));
`else
        check("h_cap_halted", 32'(halted), 32'(1'b0));
        check("h_cap_pc", 32'(pc), 32'(16'h000A));
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("h_next_irpc", 32'(ir_pc), 32'(16'h000A));
        check("h_next_pc", 32'(pc), 32'(16'h000C));
        check("h_next_halted", 32'(halted), 32'(1'b0));
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        check("h_redir_valid", 32'(ir_valid), 32'(1'b0));
        check("h_redir_pc", 32'(pc), 32'(16'h0000));
`endif

        // ---------------- reset during HALT / stall ----------------
        step(1'b0, 1'b1, 16'h0009, 1'b0);   // redirect to 8, bit 0 dropped
        check("r_redir_pc", 32'(pc), 32'(16'h0008));
        check("r_redir_valid", 32'(ir_valid), 32'(1'b0));
        step(1'b0, 1'b0, 16'h0000, 1'b0);   // capture HALT word, decode not ready
        step(1'b0, 1'b0, 16'h0000, 1'b0);   // hold
        check("r_hold_valid", 32'(ir_valid), 32'(1'b1));
        check("r_hold_irpc", 32'(ir_pc), 32'(16'h0008));
        check("r_hold_irdata", 32'(ir_data), 32'(16'hF000));
`ifdef HALTED_FETCH_EN
        check("r_hold_halted", 32'(halted), 32'(1'b1));
        check("r_hold_pc", 32'(pc), 32'(16'h0008));
`else
        check("r_hold_halted", 32'(halted), 32'(1'b0));
        check("r_hold_pc", 32'(pc), 32'(16'h000A));
`endif
        step(1'b1, 1'b1, 16'h0040, 1'b1);   // reset beats redirect and fire
        check("r_rst_pc", 32'(pc), 32'(16'h0000));
        check("r_rst_valid", 32'(ir_valid), 32'(1'b0));
        check("r_rst_irdata", 32'(ir_data), 32'(16'h0000));
        check("r_rst_irpc", 32'(ir_pc), 32'(16'h0000));
        check("r_rst_halted", 32'(halted), 32'(1'b0));
        check("r_rst_state", 32'(fetch_state), 32'(FETCH_RUN));
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("r_first_irpc", 32'(ir_pc), 32'(16'h0000));
        check("r_first_valid", 32'(ir_valid), 32'(1'b1));

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
